// File: rtl/core_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_types_pkg
//  Description : Shared types and constants for the data-memory path:
//                LSU state encoding, access-length codes (shared with
//                decode), the dmem request control packet and an alignment
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_types_pkg;

  // Data/address width of the core datapath.
  localparam int DMEM_N_BITS = 32;

  // Access-length codes as produced by decode.
  localparam logic [1:0] LSU_LEN_WORD = 2'd0;
  localparam logic [1:0] LSU_LEN_BYTE = 2'd1;
  localparam logic [1:0] LSU_LEN_HALF = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    ERR  = 3'd3,
    DONE = 3'd4
  } lsu_state_t;

  // Request control packet from decode: mtype 1 = store.
  typedef struct packed {
    logic       vld;
    logic       mtype;
    logic [1:0] len;
  } dmem_req_ctrl_t;

  // Natural alignment check. Byte accesses are always aligned. The unused
  // length code 3 is treated like a word.
  function automatic logic lsu_is_aligned(input logic [1:0] len,
                                          input logic [1:0] off);
    logic ok;
    case (len)
      LSU_LEN_BYTE: ok = 1'b1;
      LSU_LEN_HALF: ok = ~off[0];
      default:      ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage : core_types_pkg
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Purely combinational byte-lane logic for the LSU.
//                - alignment check of the incoming access
//                - store data / byte-strobe placement into word lanes
//                - load byte/half extraction with sign or zero extension
//  Ports       : st_len, st_off, st_data -> aligned, wdata, wstrb
//                ld_len, ld_off, ld_unsigned, rdata -> ld_data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import core_types_pkg::*;
#(
  parameter int N_BITS    = DMEM_N_BITS,
  parameter int STRB_BITS = N_BITS / 8
) (
  // store / incoming-access side
  input  logic [1:0]           st_len,
  input  logic [1:0]           st_off,
  input  logic [N_BITS-1:0]    st_data,
  output logic                 aligned,
  output logic [N_BITS-1:0]    wdata,
  output logic [STRB_BITS-1:0] wstrb,
  // load side (captured access attributes + raw memory word)
  input  logic [1:0]           ld_len,
  input  logic [1:0]           ld_off,
  input  logic                 ld_unsigned,
  input  logic [N_BITS-1:0]    rdata,
  output logic [N_BITS-1:0]    ld_data
);

  logic [N_BITS-1:0] shifted;
  logic              sign_bit;

  assign aligned = lsu_is_aligned(st_len, st_off);

  // Store lane placement. Halfwords shift by 16*off[1]; off[0] is zero for
  // any aligned half, so shifting by 8*off gives the same result.
  always_comb begin
    wdata = st_data;
    wstrb = {STRB_BITS{1'b1}};
    case (st_len)
      LSU_LEN_BYTE: begin
        wdata = {{(N_BITS-8){1'b0}}, st_data[7:0]} << {st_off, 3'b000};
        wstrb = {{(STRB_BITS-1){1'b0}}, 1'b1} << st_off;
      end
      LSU_LEN_HALF: begin
        wdata = {{(N_BITS-16){1'b0}}, st_data[15:0]} << {st_off[1], 4'b0000};
        wstrb = {{(STRB_BITS-2){1'b0}}, 2'b11} << st_off;
      end
      default: begin
        wdata = st_data;
        wstrb = {STRB_BITS{1'b1}};
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0 then extend.
  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    ld_data  = rdata;
    case (ld_len)
      LSU_LEN_BYTE: begin
        sign_bit = ~ld_unsigned & shifted[7];
        ld_data  = {{(N_BITS-8){sign_bit}}, shifted[7:0]};
      end
      LSU_LEN_HALF: begin
        sign_bit = ~ld_unsigned & shifted[15];
        ld_data  = {{(N_BITS-16){sign_bit}}, shifted[15:0]};
      end
      default: begin
        ld_data = rdata;
      end
    endcase
  end

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lsu
//  Description : M-stage load/store unit. Accepts one dmem request from the
//                pipeline, issues it to data memory over valid/ready, waits
//                for the load response, and presents a registered result
//                (done / ld_data / misalign) for writeback. The pipeline is
//                stalled while a transaction is in flight.
//  Ports       : clk, rst_n            clock, async active-low reset
//                vld_in, squash_in     M-stage valid and squash
//                stall_in              downstream stall (holds result)
//                req_ctrl_pkt          {vld, mtype, len}
//                ld_unsigned, addr, st_data   access attributes
//                mem_req_*             request channel to data memory
//                mem_resp_vld/rdata    load response channel
//                stall, done, ld_data, misalign   pipeline-facing results
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu
  import core_types_pkg::*;
#(
  parameter int N_BITS    = DMEM_N_BITS,
  parameter int STRB_BITS = N_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  input  logic                 squash_in,
  input  logic                 stall_in,
  input  dmem_req_ctrl_t       req_ctrl_pkt,
  input  logic                 ld_unsigned,
  input  logic [N_BITS-1:0]    addr,
  input  logic [N_BITS-1:0]    st_data,
  output logic                 mem_req_vld,
  input  logic                 mem_req_rdy,
  output logic                 mem_req_we,
  output logic [N_BITS-1:0]    mem_req_addr,
  output logic [STRB_BITS-1:0] mem_req_wstrb,
  output logic [N_BITS-1:0]    mem_req_wdata,
  input  logic                 mem_resp_vld,
  input  logic [N_BITS-1:0]    mem_resp_rdata,
  output logic                 stall,
  output logic                 done,
  output logic [N_BITS-1:0]    ld_data,
  output logic                 misalign
);

  lsu_state_t state, state_nxt;

  // Captured request
  logic                 mtype_q;
  logic [1:0]           len_q;
  logic                 unsigned_q;
  logic [1:0]           off_q;
  logic [N_BITS-1:0]    waddr_q;
  logic [N_BITS-1:0]    wdata_q;
  logic [STRB_BITS-1:0] wstrb_q;

  // Registered result
  logic [N_BITS-1:0]    ld_data_q;
  logic                 misalign_q;

  // Lane-logic results
  logic                 aligned;
  logic [N_BITS-1:0]    al_wdata;
  logic [STRB_BITS-1:0] al_wstrb;
  logic [N_BITS-1:0]    ext_data;

  logic accept;
  logic in_req;

  assign accept = vld_in & req_ctrl_pkt.vld & ~squash_in & (state == IDLE);
  assign in_req = (state == REQ);

  dmem_lane_align #(
    .N_BITS    (N_BITS),
    .STRB_BITS (STRB_BITS)
  ) u_lane_align (
    .st_len      (req_ctrl_pkt.len),
    .st_off      (addr[1:0]),
    .st_data     (st_data),
    .aligned     (aligned),
    .wdata       (al_wdata),
    .wstrb       (al_wstrb),
    .ld_len      (len_q),
    .ld_off      (off_q),
    .ld_unsigned (unsigned_q),
    .rdata       (mem_resp_rdata),
    .ld_data     (ext_data)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = aligned ? REQ : ERR;
      end
      REQ: begin
        if (mem_req_rdy) state_nxt = mtype_q ? DONE : RESP;
      end
      RESP: begin
        if (mem_resp_vld) state_nxt = DONE;
      end
      ERR: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (!stall_in) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture. Loads capture a zero strobe/data so the request channel
  // never presents write lanes for a read.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtype_q    <= 1'b0;
      len_q      <= 2'b00;
      unsigned_q <= 1'b0;
      off_q      <= 2'b00;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else if (accept) begin
      mtype_q    <= req_ctrl_pkt.mtype;
      len_q      <= req_ctrl_pkt.len;
      unsigned_q <= ld_unsigned;
      off_q      <= addr[1:0];
      waddr_q    <= {addr[N_BITS-1:2], 2'b00};
      wdata_q    <= req_ctrl_pkt.mtype ? al_wdata : '0;
      wstrb_q    <= req_ctrl_pkt.mtype ? al_wstrb : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers. Cleared on accept so a store or misaligned access
  // reports zero load data; held through DONE while stall_in is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
    end else if (state == ERR) begin
      ld_data_q  <= '0;
      misalign_q <= 1'b1;
    end else if ((state == RESP) && mem_resp_vld) begin
      ld_data_q  <= ext_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Request fields come only from registers and are zeroed outside
  // REQ so the memory sees a quiet channel when no request is pending.
  // --------------------------------------------------------------------------
  assign mem_req_vld   = in_req;
  assign mem_req_we    = in_req & mtype_q;
  assign mem_req_addr  = in_req ? waddr_q : '0;
  assign mem_req_wstrb = in_req ? wstrb_q : '0;
  assign mem_req_wdata = in_req ? wdata_q : '0;

  assign stall    = accept | (state == REQ) | (state == RESP) | (state == ERR);
  assign done     = (state == DONE);
  assign ld_data  = ld_data_q;
  assign misalign = done & misalign_q;

endmodule : dmem_lsu
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_lsu
//  Description : Self-checking bench for dmem_lsu. Directed scenarios plus
//                randomized transactions, each compared cycle by cycle
//                against an arithmetic reference model of the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;
  import core_types_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           vld_in;
  logic           squash_in;
  logic           stall_in;
  dmem_req_ctrl_t req_ctrl_pkt;
  logic           ld_unsigned;
  logic [31:0]    addr;
  logic [31:0]    st_data;
  logic           mem_req_vld;
  logic           mem_req_rdy;
  logic           mem_req_we;
  logic [31:0]    mem_req_addr;
  logic [3:0]     mem_req_wstrb;
  logic [31:0]    mem_req_wdata;
  logic           mem_resp_vld;
  logic [31:0]    mem_resp_rdata;
  logic           stall;
  logic           done;
  logic [31:0]    ld_data;
  logic           misalign;

  int vectors = 0;
  int errs    = 0;

  dmem_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vld_in         (vld_in),
    .squash_in      (squash_in),
    .stall_in       (stall_in),
    .req_ctrl_pkt   (req_ctrl_pkt),
    .ld_unsigned    (ld_unsigned),
    .addr           (addr),
    .st_data        (st_data),
    .mem_req_vld    (mem_req_vld),
    .mem_req_rdy    (mem_req_rdy),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_vld   (mem_resp_vld),
    .mem_resp_rdata (mem_resp_rdata),
    .stall          (stall),
    .done           (done),
    .ld_data        (ld_data),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from an IDLE LSU. rdy_wait = cycles with
  // mem_req_rdy low before the handshake, resp_wait = RESP cycles before the
  // response, hold = cycles of stall_in while done.
  task automatic do_txn(input bit mt, input logic [1:0] ln, input bit uns,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int rdy_wait, input int resp_wait,
                        input logic [31:0] rd, input int hold);
    int          off;
    bit          mis;
    logic [31:0] ew, sh, v, eaddr;
    logic [3:0]  es;

    // ---- reference model ----
    off   = int'(a % 4);
    eaddr = a - (a % 4);
    mis   = (ln == LSU_LEN_HALF && (off % 2) != 0) ||
            (ln != LSU_LEN_HALF && ln != LSU_LEN_BYTE && off != 0);
    if (ln == LSU_LEN_BYTE) begin
      ew = (sd % 256) << (8 * off);
      es = 4'(1 << off);
    end else if (ln == LSU_LEN_HALF) begin
      ew = (sd % 65536) << (8 * off);
      es = 4'(3 << off);
    end else begin
      ew = sd;
      es = 4'hF;
    end
    sh = rd >> (8 * off);
    if (ln == LSU_LEN_BYTE) begin
      v = sh % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (ln == LSU_LEN_HALF) begin
      v = sh % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    if (mis) v = 32'h0;

    // ---- accept cycle ----
    vld_in       = 1'b1;
    squash_in    = 1'b0;
    req_ctrl_pkt = '{vld: 1'b1, mtype: mt, len: ln};
    ld_unsigned  = uns;
    addr         = a;
    st_data      = sd;
    @(negedge clk);
    chk("accept_stall", 32'(stall), 32'd1);
    chk("accept_no_req", 32'(mem_req_vld), 32'd0);
    chk("accept_done", 32'(done), 32'd0);
    cyc_end();
    vld_in       = 1'b0;
    req_ctrl_pkt = '{vld: 1'b0, mtype: 1'b0, len: 2'd0};
    addr         = $urandom;
    st_data      = $urandom;
    ld_unsigned  = 1'($urandom);

    if (mis) begin
      @(negedge clk);
      chk("err_stall", 32'(stall), 32'd1);
      chk("err_no_req", 32'(mem_req_vld), 32'd0);
      chk("err_done", 32'(done), 32'd0);
      cyc_end();
    end else begin
      for (int w = 0; w <= rdy_wait; w++) begin
        mem_req_rdy    = (w == rdy_wait);
        mem_resp_vld   = (w != rdy_wait) ? 1'($urandom) : 1'b0;
        mem_resp_rdata = $urandom;
        @(negedge clk);
        chk("req_vld", 32'(mem_req_vld), 32'd1);
        chk("req_we", 32'(mem_req_we), 32'(mt));
        chk("req_addr", mem_req_addr, eaddr);
        chk("req_wstrb", 32'(mem_req_wstrb), mt ? 32'(es) : 32'd0);
        if (mt) chk("req_wdata", mem_req_wdata, ew);
        chk("req_stall", 32'(stall), 32'd1);
        chk("req_done", 32'(done), 32'd0);
        cyc_end();
      end
      mem_req_rdy  = 1'b0;
      mem_resp_vld = 1'b0;
      if (!mt) begin
        for (int w = 0; w <= resp_wait; w++) begin
          mem_resp_vld   = (w == resp_wait);
          mem_resp_rdata = (w == resp_wait) ? rd : $urandom;
          @(negedge clk);
          chk("resp_stall", 32'(stall), 32'd1);
          chk("resp_no_req", 32'(mem_req_vld), 32'd0);
          chk("resp_done", 32'(done), 32'd0);
          cyc_end();
        end
        mem_resp_vld = 1'b0;
      end
    end

    // ---- done phase ----
    for (int h = 0; h <= hold; h++) begin
      stall_in       = (h < hold);
      mem_resp_vld   = 1'($urandom);
      mem_resp_rdata = $urandom;
      @(negedge clk);
      chk("done", 32'(done), 32'd1);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_no_req", 32'(mem_req_vld), 32'd0);
      chk("done_misalign", 32'(misalign), 32'(mis));
      if (!mt || mis) chk("ld_data", ld_data, v);
      cyc_end();
    end
    stall_in     = 1'b0;
    mem_resp_vld = 1'b0;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_misalign", 32'(misalign), 32'd0);
    cyc_end();
  endtask

  initial begin
    rst_n          = 1'b0;
    vld_in         = 1'b0;
    squash_in      = 1'b0;
    stall_in       = 1'b0;
    req_ctrl_pkt   = '{vld: 1'b0, mtype: 1'b0, len: 2'd0};
    ld_unsigned    = 1'b0;
    addr           = 32'h0;
    st_data        = 32'h0;
    mem_req_rdy    = 1'b0;
    mem_resp_vld   = 1'b0;
    mem_resp_rdata = 32'h0;

    #12;
    chk("rst_req_vld", 32'(mem_req_vld), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_wstrb", 32'(mem_req_wstrb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_end();

    // Store byte to top lane
    do_txn(1'b1, LSU_LEN_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0, 0);
    // Signed and unsigned half loads from upper half
    do_txn(1'b0, LSU_LEN_HALF, 1'b0, 32'h0000_2002, 32'h0, 0, 0, 32'h8765_1234, 0);
    do_txn(1'b0, LSU_LEN_HALF, 1'b1, 32'h0000_2002, 32'h0, 0, 0, 32'h8765_1234, 0);
    // Word load with 4 cycles of backpressure
    do_txn(1'b0, LSU_LEN_WORD, 1'b0, 32'h0000_5000, 32'h0, 4, 2, 32'hDEAD_BEEF, 0);
    // Misaligned word
    do_txn(1'b0, LSU_LEN_WORD, 1'b0, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 0);
    // Load result held under downstream stall
    do_txn(1'b0, LSU_LEN_BYTE, 1'b0, 32'h0000_6001, 32'h0, 0, 0, 32'h1234_F078, 3);

    // Squashed and packet-invalid requests are not accepted
    vld_in       = 1'b1;
    squash_in    = 1'b1;
    req_ctrl_pkt = '{vld: 1'b1, mtype: 1'b1, len: LSU_LEN_WORD};
    addr         = 32'h0000_7000;
    @(negedge clk);
    chk("squash_stall", 32'(stall), 32'd0);
    cyc_end();
    squash_in    = 1'b0;
    req_ctrl_pkt = '{vld: 1'b0, mtype: 1'b1, len: LSU_LEN_WORD};
    @(negedge clk);
    chk("squash_no_req", 32'(mem_req_vld), 32'd0);
    chk("pktinv_stall", 32'(stall), 32'd0);
    cyc_end();
    vld_in = 1'b0;
    @(negedge clk);
    chk("pktinv_no_req", 32'(mem_req_vld), 32'd0);
    cyc_end();

    // Reset while waiting for a load response
    vld_in       = 1'b1;
    req_ctrl_pkt = '{vld: 1'b1, mtype: 1'b0, len: LSU_LEN_WORD};
    addr         = 32'h0000_4000;
    cyc_end();
    vld_in       = 1'b0;
    req_ctrl_pkt = '{vld: 1'b0, mtype: 1'b0, len: 2'd0};
    mem_req_rdy  = 1'b1;
    @(negedge clk);
    chk("rstmid_req_vld", 32'(mem_req_vld), 32'd1);
    cyc_end();
    mem_req_rdy = 1'b0;
    chk("rstmid_resp_stall", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_req", 32'(mem_req_vld), 32'd0);
    chk("rstmid_ld_data", ld_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_end();
    mem_resp_vld   = 1'b1;
    mem_resp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_resp_done", 32'(done), 32'd0);
    chk("late_resp_stall", 32'(stall), 32'd0);
    cyc_end();
    mem_resp_vld = 1'b0;
    @(negedge clk);
    chk("late_resp_done2", 32'(done), 32'd0);
    chk("late_resp_ld_data", ld_data, 32'd0);
    cyc_end();

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      bit          r_mt, r_uns;
      logic [1:0]  r_ln;
      logic [31:0] r_a;
      int          sel;
      r_mt  = 1'($urandom);
      r_uns = 1'($urandom);
      sel   = int'($urandom_range(0, 2));
      r_ln  = (sel == 0) ? LSU_LEN_BYTE : (sel == 1) ? LSU_LEN_HALF : LSU_LEN_WORD;
      r_a   = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (r_ln == LSU_LEN_HALF) r_a = r_a - (r_a % 2);
        if (r_ln == LSU_LEN_WORD) r_a = r_a - (r_a % 4);
      end
      do_txn(r_mt, r_ln, r_uns, r_a, $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule : tb_dmem_lsu
`default_nettype wire
